switch_debounce_sync: RTL and testbench
=======================================

// Module: switch_debounce_sync
// PURPOSE
//  Conditions raw slide-switch inputs before the switch PIO samples them.
//  - Each switch bit passes through a 2-FF synchroniser, then a per-bit debounce counter.
//  - Output sw_stable drives the PIO in_port directly, so software reads only settled, metastability-free levels.
//  - Sits between the board switch pins and the Avalon switch PIO.
// PARAMETERS
//  WIDTH            4      number of switch bits
//  DEBOUNCE_CYCLES  50000  consecutive clk cycles a new level must persist (1 ms @ 50 MHz); legal >= 1
//  CNT_W (localparam)  $clog2(DEBOUNCE_CYCLES+1)  counter width, not overridable
// PORTS
//  clk         in   1      system clock; one clock domain
//  reset       in   1      asynchronous, active-high reset
//  sw_raw      in   WIDTH  raw switch pins, asynchronous to clk
//  sw_stable   out  WIDTH  debounced levels, registered; feeds PIO in_port
//  sw_changed  out  WIDTH  1-cycle change pulse per bit (present only with macro, see CONFIGURATION)
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is asynchronous and active-high.
//  - Reset: clears sync FFs, counters, sw_stable and sw_changed to 0 immediately.
//    Switches held high through reset reach sw_stable only after the full latency below.
//  - Synchroniser: s1 <= sw_raw; s2 <= s1. Only s2 is used downstream.
//  - Per-bit two-state FSM:
//    - SETTLED: s2 == sw_stable, cnt = 0.
//    - PENDING: s2 != sw_stable, cnt counts up by 1 per cycle.
//    - SETTLED -> PENDING when s2 != sw_stable (cnt <= 1).
//    - PENDING -> SETTLED when s2 == sw_stable again (bounce): cnt <= 0, sw_stable unchanged.
//    - PENDING -> SETTLED when cnt == DEBOUNCE_CYCLES-1 and mismatch persists: sw_stable <= s2, cnt <= 0.
//  - Latency: a level held steadily appears on sw_stable exactly 2+DEBOUNCE_CYCLES rising edges after the first edge sampling it.
//  - Glitches: any excursion shorter than DEBOUNCE_CYCLES cycles (after sync) never reaches sw_stable.
//  - Counter: saturates at DEBOUNCE_CYCLES-1; never wraps.
//  - Independence: bits are fully independent; simultaneous transitions on several bits each follow their own counter.
//  - DEBOUNCE_CYCLES=1: sw_stable follows s2 with a 1-cycle delay.
//  - Reset mid-count: the pending transition is discarded; counting restarts from 0 after release.
// CONFIGURATION
//  Macro SWITCH_DEBOUNCE_CHANGE_PULSE_EN:
//  - Defined: sw_changed[i] is 1 for exactly one cycle, registered, in the same cycle sw_stable[i] takes its new value; otherwise 0.
//  - Undefined: sw_changed port and its logic are omitted; sw_stable behaviour is identical.
// STRUCTURE
//  - Shared package/include switch_pkg:
//    - localparam DEFAULT_DEBOUNCE_CYCLES = 50000.
//    - FSM state encoding: SW_SETTLED = 1'b0, SW_PENDING = 1'b1.
//  - Sub-module switch_debounce_bit:
//    - One bit: 2-FF sync, counter, FSM, optional pulse.
//    - Instantiated WIDTH times via generate in switch_debounce_sync.
// TESTING  (DEBOUNCE_CYCLES=8, WIDTH=4, macro defined unless noted)
//  1. Reset with sw_raw=4'b0000, release -> sw_stable=4'b0000, sw_changed=0 for 50 cycles.
//  2. sw_raw 0000->0001, held -> sw_stable=0001 exactly 10 edges later; sw_changed=0001 for 1 cycle.
//  3. sw_raw[1] toggles every 3 cycles for 30 cycles, then held 1 -> sw_stable[1]=0 during bounce; rises 10 edges after last toggle.
//  4. sw_raw[2] high for 7 cycles, then 0 -> sw_stable and sw_changed stay 0000.
//  5. sw_raw=1111 held, reset pulsed at cycle 5 of counting -> outputs 0 during reset; sw_stable=1111 10 edges after release.
//  6. Macro undefined, rerun test 2 -> identical sw_stable timing; build has no sw_changed port.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the switch debounce/synchroniser block: default debounce
// length and the per-bit FSM state encoding.
package switch_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  typedef enum logic {
    SW_SETTLED = 1'b0,
    SW_PENDING = 1'b1
  } sw_state_e;

endpackage : switch_pkg

// File: rtl/switch_debounce_sync_if.sv
// Switch-side bundle: raw pins in, debounced levels (and optional change pulses) out.
// Optional sw_changed member controlled by SWITCH_DEBOUNCE_CHANGE_PULSE_EN.
interface switch_debounce_sync_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  logic [WIDTH-1:0] sw_changed;

  modport master (output sw_raw, input sw_stable, input sw_changed);
  modport slave  (input sw_raw, output sw_stable, output sw_changed);
`else
  modport master (output sw_raw, input sw_stable);
  modport slave  (input sw_raw, output sw_stable);
`endif

endinterface : switch_debounce_sync_if

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-FF synchroniser, debounce counter and settle/pending FSM.
// Optional registered change pulse under SWITCH_DEBOUNCE_CHANGE_PULSE_EN.
module switch_debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  output logic sw_changed,
`endif
  output logic sw_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sw_state_e        state_q, state_d;

  // A mismatch that reaches CNT_MAX is accepted; with DEBOUNCE_CYCLES=1 that
  // happens straight from SETTLED, giving a one-cycle follow of s2.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    unique case (state_q)
      SW_SETTLED: begin
        if (s2_q != stable_q) begin
          if (cnt_q == CNT_MAX) begin
            stable_d  = s2_q;
            changed_d = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = SW_PENDING;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      SW_PENDING: begin
        if (s2_q == stable_q) begin
          state_d = SW_SETTLED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = SW_SETTLED;
          stable_d  = s2_q;
          changed_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SW_SETTLED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= SW_SETTLED;
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= sw_raw;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  assign sw_stable = stable_q;

`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  assign sw_changed = changed_q;
`else
  logic unused_changed;
  assign unused_changed = changed_q;
`endif

endmodule : switch_debounce_bit

// File: rtl/switch_debounce_sync.sv
// Conditions raw slide switches for the switch PIO: per-bit synchroniser + debounce.
// Optional change-pulse output enabled by SWITCH_DEBOUNCE_CHANGE_PULSE_EN.
module switch_debounce_sync
  import switch_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  switch_debounce_sync_if.slave sw_if
);

  logic [WIDTH-1:0] stable_w;
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  logic [WIDTH-1:0] changed_w;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .sw_raw    (sw_if.sw_raw[i]),
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
      .sw_changed(changed_w[i]),
`endif
      .sw_stable (stable_w[i])
    );
  end

  assign sw_if.sw_stable = stable_w;
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
  assign sw_if.sw_changed = changed_w;
`endif

endmodule : switch_debounce_sync

// File: tb/tb_switch_debounce_sync.sv
// Directed bench for switch_debounce_sync with DEBOUNCE_CYCLES=8, WIDTH=4.
// Change-pulse checks are compiled in only with SWITCH_DEBOUNCE_CHANGE_PULSE_EN.
module tb_switch_debounce_sync;

  localparam int W = 4;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  switch_debounce_sync_if #(.WIDTH(W)) sw_if ();

  switch_debounce_sync #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sw_if(sw_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] raw;
    int           edges;
    logic [W-1:0] exp_stable;
    logic [W-1:0] exp_changed;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [W-1:0] exp_s,
                           input logic [W-1:0] exp_c);
    checks++;
    if (sw_if.sw_stable !== exp_s) begin
      errors++;
      $display("FAIL %s sw_stable actual=%b required=%b t=%0t", name, sw_if.sw_stable, exp_s, $time);
    end
`ifdef SWITCH_DEBOUNCE_CHANGE_PULSE_EN
    checks++;
    if (sw_if.sw_changed !== exp_c) begin
      errors++;
      $display("FAIL %s sw_changed actual=%b required=%b t=%0t", name, sw_if.sw_changed, exp_c, $time);
    end
`else
    if (exp_c === 'x) $display("note: unexpected x in change expectation");
`endif
  endtask

  initial begin
    // {raw applied, edges, sw_stable and sw_changed expected after each of those edges}
    vecs.push_back('{4'b0001, 9, 4'b0000, 4'b0000});  // rise: nothing for 9 edges
    vecs.push_back('{4'b0001, 1, 4'b0001, 4'b0001});  // 10th edge
    vecs.push_back('{4'b0001, 5, 4'b0001, 4'b0000});
    vecs.push_back('{4'b0101, 7, 4'b0001, 4'b0000});  // 7-cycle glitch on bit 2
    vecs.push_back('{4'b0001, 10, 4'b0001, 4'b0000});
    vecs.push_back('{4'b0000, 9, 4'b0001, 4'b0000});  // fall of bit 0
    vecs.push_back('{4'b0000, 1, 4'b0000, 4'b0001});
    vecs.push_back('{4'b0000, 3, 4'b0000, 4'b0000});
    vecs.push_back('{4'b1010, 9, 4'b0000, 4'b0000});  // two bits together
    vecs.push_back('{4'b1010, 1, 4'b1010, 4'b1010});
    vecs.push_back('{4'b1010, 2, 4'b1010, 4'b0000});
    vecs.push_back('{4'b0011, 9, 4'b1010, 4'b0000});  // bit3 falls, bit0 rises, bit1 holds
    vecs.push_back('{4'b0011, 1, 4'b0011, 4'b1001});
    vecs.push_back('{4'b0011, 2, 4'b0011, 4'b0000});
    vecs.push_back('{4'b0000, 9, 4'b0011, 4'b0000});
    vecs.push_back('{4'b0000, 1, 4'b0000, 4'b0011});
    vecs.push_back('{4'b0000, 2, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0100, 8, 4'b0000, 4'b0000});  // exactly 8-cycle pulse is accepted
    vecs.push_back('{4'b0000, 1, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 1, 4'b0100, 4'b0100});
    vecs.push_back('{4'b0000, 7, 4'b0100, 4'b0000});
    vecs.push_back('{4'b0000, 1, 4'b0000, 4'b0100});
    vecs.push_back('{4'b0000, 2, 4'b0000, 4'b0000});

    // Reset with all switches low
    sw_if.sw_raw = '0;
    reset = 1'b1;
    #1;
    check_out("reset_async", 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("in_reset", 4'b0000, 4'b0000);
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      check_out("idle_after_reset", 4'b0000, 4'b0000);
    end

    // Table-driven vectors
    for (int v = 0; v < vecs.size(); v++) begin
      sw_if.sw_raw = vecs[v].raw;
      for (int e = 0; e < vecs[v].edges; e++) begin
        step();
        check_out($sformatf("vec%0d_edge%0d", v, e), vecs[v].exp_stable, vecs[v].exp_changed);
      end
    end

    // Bounce on bit 1: 3-cycle segments for 30 cycles, then held high
    for (int seg = 0; seg < 10; seg++) begin
      sw_if.sw_raw = (seg % 2 == 0) ? 4'b0010 : 4'b0000;
      for (int e = 0; e < 3; e++) begin
        step();
        check_out("bounce", 4'b0000, 4'b0000);
      end
    end
    sw_if.sw_raw = 4'b0010;
    for (int e = 1; e <= 9; e++) begin
      step();
      check_out("bounce_settling", 4'b0000, 4'b0000);
    end
    step();
    check_out("bounce_settled", 4'b0010, 4'b0010);
    step();
    check_out("bounce_after", 4'b0010, 4'b0000);

    // All high, reset pulsed mid-count (counter at 5 after 7 edges)
    sw_if.sw_raw = 4'b1111;
    for (int e = 0; e < 7; e++) begin
      step();
      check_out("pre_reset_count", 4'b0010, 4'b0000);
    end
    reset = 1'b1;
    #1;
    check_out("midcount_reset_async", 4'b0000, 4'b0000);
    for (int e = 0; e < 2; e++) begin
      step();
      check_out("midcount_in_reset", 4'b0000, 4'b0000);
    end
    reset = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      step();
      check_out("post_reset_count", 4'b0000, 4'b0000);
    end
    step();
    check_out("post_reset_settled", 4'b1111, 4'b1111);
    step();
    check_out("post_reset_hold", 4'b1111, 4'b0000);

    // Asynchronous clear of a settled value, no clock edge in between
    reset = 1'b1;
    #2;
    check_out("async_clear", 4'b0000, 4'b0000);
    step();
    reset = 1'b0;
    step();
    check_out("after_final_reset", 4'b0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_switch_debounce_sync
